// File: rtl/mem_op_sequencer.sv
// Hardwired control sequencer for ld/ldi/st on Datapath2.
// Moore FSM: every strobe decodes from registered state, latched class and wait count.
module mem_op_sequencer #(
  parameter int OP_W     = 5,
  parameter int ALU_W    = 5,
  parameter int ALU_INC  = 12,
  parameter int ALU_ADD  = 2,
  parameter int MEM_WAIT = 1,
  parameter logic [OP_W-1:0] OP_LD  = 5'b00000,
  parameter logic [OP_W-1:0] OP_LDI = 5'b00001,
  parameter logic [OP_W-1:0] OP_ST  = 5'b00010
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Cout,
  output logic [ALU_W-1:0] ALU_Control,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [3:0]       dbg_state
);

  localparam int WCNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {C_LD, C_LDI, C_ST} cls_t;

  state_t            state, state_nxt;
  cls_t              cls, op_cls;
  logic              op_ok;
  logic [WCNT_W-1:0] wcnt;
  logic              mem_exit;

  assign mem_exit  = (wcnt == WCNT_MAX) && mem_ready;
  assign dbg_state = state;

  always_comb begin
    op_cls = C_LD;
    op_ok  = 1'b1;
    if (opcode == OP_LD)       op_cls = C_LD;
    else if (opcode == OP_LDI) op_cls = C_LDI;
    else if (opcode == OP_ST)  op_cls = C_ST;
    else                       op_ok  = 1'b0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      cls   <= C_LD;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T3) cls <= op_cls;
      // Count restarts on every state change so each memory state starts at 0.
      if (state_nxt != state)  wcnt <= '0;
      else if (wcnt != WCNT_MAX) wcnt <= wcnt + WCNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_T0;
      S_T0:      state_nxt = S_T1;
      S_T1:      if (mem_exit) state_nxt = S_T2;
      S_T2:      state_nxt = S_T3;
      S_T3:      state_nxt = op_ok ? S_T4 : S_ILLEGAL;
      S_T4:      state_nxt = S_T5;
      S_T5:      state_nxt = (cls == C_LDI) ? S_DONE : S_T6;
      S_T6:      if (cls == C_ST || mem_exit) state_nxt = S_T7;
      S_T7:      if (cls == C_LD || mem_exit) state_nxt = S_DONE;
      S_DONE:    state_nxt = run ? S_T0 : S_IDLE;
      S_ILLEGAL: if (!run) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0; Zin = 1'b0;
    PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Read = 1'b0;
    Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; ALU_Control = '0;
    busy    = (state != S_IDLE) && (state != S_ILLEGAL);
    done    = (state == S_DONE);
    illegal = (state == S_ILLEGAL);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_W'(ALU_INC);
      end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        // PC is loaded from Z only in the first count so it advances once.
        if (wcnt == '0) begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_T4: begin Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_W'(ALU_ADD); end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == C_LDI) begin Gra = 1'b1; Rin = 1'b1; end
        else MARin = 1'b1;
      end
      S_T6: begin
        MDRin = 1'b1;
        if (cls == C_ST) begin Gra = 1'b1; Rout = 1'b1; end
        else Read = 1'b1;
      end
      S_T7: begin
        if (cls == C_ST) Write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_op_sequencer.md
# mem_op_sequencer

Hardwired control sequencer for the memory-class instructions `ld`, `ldi` and `st`. It replaces hand-driven testbench control with RTL that drives the Datapath2 control strobes cycle by cycle. It adds instruction decode, a configurable number of memory wait states, a `mem_ready` handshake, back-to-back instruction issue and illegal-opcode trapping. It sits between the future top-level control unit and Datapath2, and its strobe outputs connect 1:1 to the same-named Datapath2 inputs.

## Interface
- `OP_W`, 5: opcode width, taken from IR[31:27].
- `ALU_W`, 5: width of the ALU opcode bus.
- `ALU_INC`, 12: ALU code for PC+1.
- `ALU_ADD`, 2: ALU code for add.
- `MEM_WAIT`, 1: minimum cycles a Read/Write strobe is held. Legal range is ≥1.
- `OP_LD`, 5'b00000; `OP_LDI`, 5'b00001; `OP_ST`, 5'b00010: decoded opcodes.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `run` in 1: start or continue issuing instructions.
- `opcode` in OP_W: IR[31:27] from the datapath.
- `mem_ready` in 1: memory access complete.
- `PCout`, `Zlowout`, `MDRout`, `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin` out 1 each: datapath strobes.
- `Read`, `Write`, `Gra`, `Grb`, `Rin`, `Rout`, `BAout`, `Cout` out 1 each: datapath strobes.
- `ALU_Control` out ALU_W: ALU operation code.
- `busy` out 1: high in any state except IDLE and ILLEGAL.
- `done` out 1: one-cycle pulse on instruction retire.
- `illegal` out 1: high while in ILLEGAL.

## Operation
- **State register:** Moore FSM with states IDLE, T0–T7, DONE, ILLEGAL, plus a wait counter `wcnt` of width clog2(MEM_WAIT+1).
- **Output decode:** all outputs decode from registered state and `wcnt` only. No input reaches an output combinationally.
- **Strobes asserted per state** (every unlisted strobe is 0; `ALU_Control` is 0 unless listed):
  - T0: PCout, MARin, Zin, ALU_Control=ALU_INC.
  - T1 (memory state): Read and MDRin every cycle. Zlowout and PCin only while `wcnt`==0, so PC increments exactly once.
  - T2: MDRout, IRin.
  - T3: Grb, BAout, Yin. `opcode` is sampled at the end of T3.
  - T4: Cout, Zin, ALU_Control=ALU_ADD.
  - T5, `ld`/`st`: Zlowout, MARin.
  - T5, `ldi`: Zlowout, Gra, Rin. Next state is DONE.
  - T6, `ld` (memory state): Read, MDRin.
  - T6, `st`: Gra, Rout, MDRin, with Read=0.
  - T7, `ld`: MDRout, Gra, Rin.
  - T7, `st` (memory state): Write.
- **Opcode tracking:** the opcode class is latched in a 2-bit register at the end of T3. States T5–T7 use the latched class, not the live `opcode` input.
- **Illegal opcode:** an opcode other than the three decoded values at the end of T3 sends the FSM to ILLEGAL. ILLEGAL holds all strobes at 0 and stays there until `run`=0, then goes to IDLE.
- **Memory states:** `wcnt` clears on entry and counts up, saturating at MEM_WAIT-1. The state exits when `wcnt`==MEM_WAIT-1 and `mem_ready`=1; otherwise it holds with strobes unchanged.
- **Transitions:**
  - IDLE→T0 when `run`=1.
  - DONE→T0 when `run`=1, otherwise DONE→IDLE.
  - `run` dropping mid-instruction does not abort; the instruction completes.
- **Reset:** `clr`=0 at any time, including mid-access, forces IDLE and `wcnt`=0. Because outputs decode from state, every output is 0 during reset, including `ALU_Control`, `busy`, `done` and `illegal`.

## Timing
- **Edge numbering:** `run` is sampled high at edge 0; T0 occupies cycle 1.
- **Latency with `mem_ready` tied high** (W = MEM_WAIT):
  - `ld`: T0(1), T1(W), T2–T5(4), T6(W), T7(1), so `done` is high in cycle 6+2W+1.
  - `st`: same as `ld`, with T6 = 1 cycle and T7 = W cycles.
  - `ldi`: `done` is high in cycle 5+W+1.
- **Back-to-back issue:** with `run` held high, DONE is followed directly by T0, giving one dead cycle between instructions.
- **`mem_ready` low:** each cycle it is low at the exit point adds exactly one cycle to that memory state.
- **`done`:** exactly one cycle wide per retired instruction. It never asserts for an illegal opcode.

## Test plan
- **`ld`, MEM_WAIT=1, `mem_ready`=1, `run` pulsed 1 cycle:** strobes match the per-state list in cycles 1–8; `done`=1 in cycle 9 only; IDLE in cycle 10; `busy` is high in cycles 1–9.
- **`ldi`, MEM_WAIT=1:** T5 shows Zlowout, Gra and Rin together; `done` in cycle 7; MARin never asserts after cycle 1.
- **`st`, MEM_WAIT=3, `mem_ready`=1:** Read is high in cycles 2–4 with PCin only in cycle 2; Write is high in cycles 10–12; `done` in cycle 13.
- **`ld`, MEM_WAIT=1, `mem_ready` low for 2 cycles at T6 entry:** T6 lasts 3 cycles with Read and MDRin held; `done` moves from cycle 9 to cycle 11.
- **`opcode`=5'b11111:** `illegal`=1 from cycle 5; `done` never asserts; `illegal` drops one cycle after `run`=0.
- **`clr` driven low mid-T6 of `ld`, between clock edges:** all outputs are 0 immediately, without waiting for an edge. After release with `run`=1, T0 strobes appear one cycle later.
